// File: rtl/ahbl_arb_pkg.sv
// ahbl_arb_pkg: shared types and helpers for the AHB-Lite slave port arbiter.
package ahbl_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GRANTED,
        ST_LOCKED
    } arb_state_t;

    localparam int MIN_MASTERS = 2;
    localparam int MAX_MASTERS = 16;

    function automatic logic [3:0] onehot_to_idx(input logic [15:0] oh);
        logic [3:0] idx;
        idx = '0;
        for (int i = 0; i < 16; i++)
            if (oh[i]) idx |= 4'(i);
        return idx;
    endfunction

endpackage

// File: rtl/ahbl_rr_pick.sv
// ahbl_rr_pick: combinational round-robin picker; scans from pointer+1 with wrap,
// skipping masked requesters, and returns a one-hot winner plus its index.
module ahbl_rr_pick #(
    parameter int N    = 4,
    parameter int IDXW = $clog2(N)
) (
    input  logic [N-1:0]    i_req,
    input  logic [IDXW-1:0] i_ptr,
    input  logic [N-1:0]    i_mask,
    output logic [N-1:0]    o_win,
    output logic [IDXW-1:0] o_win_idx
);

    logic [N-1:0] w_cand;

    assign w_cand = i_req & ~i_mask;

    // Walk farthest-first so the nearest candidate after the pointer overwrites last.
    always_comb begin
        o_win     = '0;
        o_win_idx = '0;
        for (int k = N; k >= 1; k--) begin
            if (w_cand[IDXW'((int'(i_ptr) + k) % N)]) begin
                o_win = '0;
                o_win[IDXW'((int'(i_ptr) + k) % N)] = 1'b1;
                o_win_idx = IDXW'((int'(i_ptr) + k) % N);
            end
        end
    end

endmodule

// File: rtl/ahbl_slave_port_arbiter.sv
// ahbl_slave_port_arbiter: round-robin owner of one AHB-Lite slave port with
// HMASTLOCK support; tracks address-phase (GRANT) and data-phase (DSEL) owners.
module ahbl_slave_port_arbiter
    import ahbl_arb_pkg::*;
#(
    parameter  int NUM_MASTERS = 4,
    localparam int IDXW        = $clog2(NUM_MASTERS)
) (
    input  logic                   i_hclk,
    input  logic                   i_hreset,
    input  logic [NUM_MASTERS-1:0] i_mreq,
    input  logic [NUM_MASTERS-1:0] i_mlock,
    input  logic                   i_hready_s,
    output logic [NUM_MASTERS-1:0] o_grant,
    output logic [IDXW-1:0]        o_grant_idx,
    output logic                   o_svalid,
    output logic                   o_slock,
    output logic [NUM_MASTERS-1:0] o_mack,
    output logic [NUM_MASTERS-1:0] o_dsel,
    output logic [IDXW-1:0]        o_dsel_idx,
    output logic                   o_dvalid
);

    if (NUM_MASTERS < MIN_MASTERS || NUM_MASTERS > MAX_MASTERS) begin : g_bad_num_masters
        $error("ahbl_slave_port_arbiter: NUM_MASTERS out of range");
    end

    arb_state_t             r_state, w_state_nxt;
    logic [NUM_MASTERS-1:0] r_grant, r_dsel, w_grant_nxt, w_win;
    logic [IDXW-1:0]        r_ptr, w_ptr_nxt, w_win_idx;
    logic                   w_arb, w_hold_lock;

    assign o_grant     = r_grant;
    assign o_dsel      = r_dsel;
    assign o_dvalid    = |r_dsel;
    assign o_grant_idx = IDXW'(onehot_to_idx(16'(r_grant)));
    assign o_dsel_idx  = IDXW'(onehot_to_idx(16'(r_dsel)));
    assign o_mack      = r_grant & i_mreq & {NUM_MASTERS{i_hready_s}};
    assign o_svalid    = |(r_grant & i_mreq);
    assign o_slock     = |(r_grant & i_mreq & i_mlock);
    assign w_hold_lock = |(o_mack & i_mlock);
    assign w_arb       = (r_state == ST_IDLE) || (|o_mack);

    // The acknowledged master is masked so a waiting competitor always gets the next slot.
    ahbl_rr_pick #(.N(NUM_MASTERS)) u_pick (
        .i_req     (i_mreq),
        .i_ptr     (r_ptr),
        .i_mask    (o_mack),
        .o_win     (w_win),
        .o_win_idx (w_win_idx)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_ptr_nxt   = r_ptr;
        if (w_hold_lock) begin
            w_state_nxt = ST_LOCKED;
        end else if (w_arb) begin
            w_state_nxt = !(|w_win) ? ST_IDLE : (|(w_win & i_mlock)) ? ST_LOCKED : ST_GRANTED;
            w_grant_nxt = w_win;
            w_ptr_nxt   = (|w_win) ? w_win_idx : r_ptr;
        end
    end

    always_ff @(posedge i_hclk or posedge i_hreset) begin
        if (i_hreset) begin
            r_state <= ST_IDLE;
            r_grant <= '0;
            r_dsel  <= '0;
            r_ptr   <= IDXW'(NUM_MASTERS - 1);
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_ptr   <= w_ptr_nxt;
            if (i_hready_s) r_dsel <= r_grant & i_mreq;
        end
    end

endmodule

// File: tb/tb_ahbl_slave_port_arbiter.sv
// tb_ahbl_slave_port_arbiter: directed self-checking bench for the slave port arbiter.
module tb_ahbl_slave_port_arbiter;

    logic       clk = 1'b0;
    logic       hreset;
    logic [3:0] mreq, mlock;
    logic       hready;
    logic [3:0] grant, mack, dsel;
    logic [1:0] grant_idx, dsel_idx;
    logic       svalid, slock, dvalid;
    int         n_tests = 0;
    int         n_fail  = 0;

    always #5 clk = ~clk;

    ahbl_slave_port_arbiter #(.NUM_MASTERS(4)) dut (
        .i_hclk      (clk),
        .i_hreset    (hreset),
        .i_mreq      (mreq),
        .i_mlock     (mlock),
        .i_hready_s  (hready),
        .o_grant     (grant),
        .o_grant_idx (grant_idx),
        .o_svalid    (svalid),
        .o_slock     (slock),
        .o_mack      (mack),
        .o_dsel      (dsel),
        .o_dsel_idx  (dsel_idx),
        .o_dvalid    (dvalid)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        hreset = 1'b1;
        mreq   = '0;
        mlock  = '0;
        hready = 1'b1;
        tick();
        mreq = '1;
        #1;
        chk("rst_grant", 32'(grant), 0);
        chk("rst_mack", 32'(mack), 0);
        chk("rst_dsel", 32'(dsel), 0);
        chk("rst_svalid", 32'(svalid), 0);
        chk("rst_slock", 32'(slock), 0);
        chk("rst_dvalid", 32'(dvalid), 0);
        @(negedge clk);
        hreset = 1'b0;
        mreq   = '0;
    endtask

    initial begin
        // Single request from idle: grant, accept, data phase.
        do_reset();
        mreq = 'b0001;
        #1;
        chk("t1_pre_grant", 32'(grant), 0);
        tick();
        chk("t1_grant", 32'(grant), 'b0001);
        chk("t1_grant_idx", 32'(grant_idx), 0);
        chk("t1_svalid", 32'(svalid), 1);
        chk("t1_mack", 32'(mack), 'b0001);
        chk("t1_dsel_early", 32'(dsel), 0);
        tick();
        mreq = '0;
        #1;
        chk("t1_dsel", 32'(dsel), 'b0001);
        chk("t1_dvalid", 32'(dvalid), 1);
        chk("t1_dsel_idx", 32'(dsel_idx), 0);
        chk("t1_grant_idle", 32'(grant), 0);
        chk("t1_mack_idle", 32'(mack), 0);
        tick();
        chk("t1_dsel_clr", 32'(dsel), 0);

        // All masters requesting: strict rotation with no bubbles.
        do_reset();
        mreq = 'b1111;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("t2_grant", 32'(grant), 32'(1 << (i % 4)));
            chk("t2_mack", 32'(mack), 32'(1 << (i % 4)));
            chk("t2_grant_idx", 32'(grant_idx), 32'(i % 4));
            if (i > 0) chk("t2_dsel", 32'(dsel), 32'(1 << ((i - 1) % 4)));
        end

        // Stall of master 2 behind master 0's data phase.
        do_reset();
        mreq = 'b0101;
        tick();
        chk("t3_grant0", 32'(grant), 'b0001);
        tick();
        mreq   = 'b0100;
        hready = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) tick();
            chk("t3_grant_stall", 32'(grant), 'b0100);
            chk("t3_dsel_stall", 32'(dsel), 'b0001);
            chk("t3_mack_stall", 32'(mack), 0);
        end
        tick();
        hready = 1'b1;
        #1;
        chk("t3_mack2", 32'(mack), 'b0100);
        chk("t3_dsel_hold", 32'(dsel), 'b0001);
        tick();
        mreq = '0;
        #1;
        chk("t3_dsel2", 32'(dsel), 'b0100);
        chk("t3_grant_idle", 32'(grant), 0);

        // Locked sequence by master 1 while master 3 waits.
        do_reset();
        mreq  = 'b1010;
        mlock = 'b0010;
        tick();
        chk("t4_grant_c1", 32'(grant), 'b0010);
        chk("t4_slock_c1", 32'(slock), 1);
        chk("t4_mack_c1", 32'(mack), 'b0010);
        tick();
        chk("t4_grant_c2", 32'(grant), 'b0010);
        chk("t4_mack_c2", 32'(mack), 'b0010);
        tick();
        mreq = 'b1000;
        #1;
        chk("t4_grant_idle", 32'(grant), 'b0010);
        chk("t4_svalid_idle", 32'(svalid), 0);
        chk("t4_slock_idle", 32'(slock), 0);
        tick();
        mreq = 'b1010;
        #1;
        chk("t4_grant_c4", 32'(grant), 'b0010);
        chk("t4_mack_c4", 32'(mack), 'b0010);
        tick();
        mlock = '0;
        #1;
        chk("t4_grant_c5", 32'(grant), 'b0010);
        chk("t4_slock_c5", 32'(slock), 0);
        tick();
        mreq = 'b1000;
        #1;
        chk("t4_grant_m3", 32'(grant), 'b1000);
        chk("t4_mack_m3", 32'(mack), 'b1000);

        // Two-cycle ERROR on master 0's data phase keeps DSEL steady.
        do_reset();
        mreq = 'b0011;
        tick();
        chk("t5_grant0", 32'(grant), 'b0001);
        tick();
        mreq   = 'b0010;
        hready = 1'b0;
        #1;
        chk("t5_dsel_err1", 32'(dsel), 'b0001);
        chk("t5_grant_err1", 32'(grant), 'b0010);
        chk("t5_mack_err1", 32'(mack), 0);
        tick();
        hready = 1'b1;
        #1;
        chk("t5_dsel_err2", 32'(dsel), 'b0001);
        chk("t5_mack_err2", 32'(mack), 'b0010);
        tick();
        mreq = '0;
        #1;
        chk("t5_dsel_next", 32'(dsel), 'b0010);
        chk("t5_grant_idle", 32'(grant), 0);

        // Asynchronous reset while locked with a data phase pending.
        do_reset();
        mreq  = 'b0001;
        mlock = 'b0001;
        tick();
        chk("t6_grant_c1", 32'(grant), 'b0001);
        chk("t6_slock_c1", 32'(slock), 1);
        tick();
        chk("t6_grant_c2", 32'(grant), 'b0001);
        chk("t6_dsel_c2", 32'(dsel), 'b0001);
        #2;
        hreset = 1'b1;
        #1;
        chk("t6_grant_rst", 32'(grant), 0);
        chk("t6_dsel_rst", 32'(dsel), 0);
        chk("t6_slock_rst", 32'(slock), 0);
        chk("t6_dvalid_rst", 32'(dvalid), 0);
        @(negedge clk);
        hreset = 1'b0;
        mreq   = 'b1111;
        mlock  = '0;
        tick();
        chk("t6_first_grant", 32'(grant), 'b0001);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
